reaction_game_multi: RTL and testbench

Parametrised N-player reaction-game controller, the successor to the fixed two-player game core. It sequences blink → random wait → race → result and detects fouls, timeouts and match wins. It keeps per-player saturating scores, and exposes state, timer and winner data for the board-level display and LED wrapper. It runs on the system clock, with all timing gated by an external 1 ms tick.

---
 rtl/reaction_game_multi_if.sv | 31 +++
 rtl/reaction_game_multi.sv | 178 +++++++++++++++++
 tb/tb_reaction_game_multi.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_game_multi_if.sv
// Signal bundle between the reaction-game core and its board wrapper.
// The wrapper drives the master side; the game core uses the slave side.
interface reaction_game_multi_if #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned TIMER_W     = 20,
  parameter int unsigned RAND_W      = 14,
  parameter int unsigned SCORE_W     = 4
);
  logic                           ms_tick;
  logic [NUM_PLAYERS-1:0]         btn;
  logic                           start;
  logic [RAND_W-1:0]              rand_ms;
  logic [2:0]                     state;
  logic                           blink;
  logic [TIMER_W-1:0]             elapsed_ms;
  logic [TIMER_W-1:0]             winner_ms;
  logic [2:0]                     winner_id;
  logic [2:0]                     cheater_id;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic                           round_done;

  modport master (
    output ms_tick, btn, start, rand_ms,
    input  state, blink, elapsed_ms, winner_ms, winner_id, cheater_id, scores, round_done
  );

  modport slave (
    input  ms_tick, btn, start, rand_ms,
    output state, blink, elapsed_ms, winner_ms, winner_id, cheater_id, scores, round_done
  );
endinterface

// File: rtl/reaction_game_multi.sv
// N-player reaction game: blink, random wait, race, result; tracks fouls,
// timeouts, saturating per-player scores and match wins.
module reaction_game_multi #(
  parameter int unsigned NUM_PLAYERS   = 4,
  parameter int unsigned TIMER_W       = 20,
  parameter int unsigned RAND_W        = 14,
  parameter int unsigned SCORE_W       = 4,
  parameter int unsigned WIN_SCORE     = 5,
  parameter int unsigned BLINK_MS      = 2000,
  parameter int unsigned BLINK_HALF_MS = 250,
  parameter int unsigned MIN_DELAY_MS  = 500,
  parameter int unsigned TIMEOUT_MS    = 5000
) (
  input logic                  clk,
  input logic                  reset,
  reaction_game_multi_if.slave gif
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BLINK      = 3'd1,
    S_WAIT       = 3'd2,
    S_RACE       = 3'd3,
    S_RESULT     = 3'd4,
    S_FOUL       = 3'd5,
    S_TIMEOUT    = 3'd6,
    S_MATCH_OVER = 3'd7
  } state_e;

  localparam logic [TIMER_W-1:0] BLINK_LAST   = TIMER_W'(BLINK_MS - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST    = TIMER_W'(BLINK_HALF_MS - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_MS - 1);
  localparam logic [TIMER_W-1:0] MIN_DELAY    = TIMER_W'(MIN_DELAY_MS);
  localparam logic [SCORE_W-1:0] WIN_VAL      = SCORE_W'(WIN_SCORE);

  state_e                 state_q;
  logic                   blink_q;
  logic [TIMER_W-1:0]     cnt_q;
  logic [TIMER_W-1:0]     phase_q;
  logic [TIMER_W-1:0]     delay_q;
  logic [TIMER_W-1:0]     elapsed_q;
  logic [TIMER_W-1:0]     winner_ms_q;
  logic [2:0]             winner_id_q;
  logic [2:0]             cheater_id_q;
  logic                   round_done_q;
  logic [NUM_PLAYERS-1:0] btn_prev_q;
  logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];

  logic [NUM_PLAYERS-1:0] press;
  logic [NUM_PLAYERS-1:0] first_hot;
  logic                   any_press;
  logic [2:0]             press_idx;
  logic [SCORE_W-1:0]     cur_score;
  logic [SCORE_W-1:0]     nxt_score;
  logic                   match_win;
  logic [RAND_W-1:0]      rand_v;
  logic [TIMER_W-1:0]     delay_d;

  // Lowest-index press takes priority; its score is fetched in the same pass.
  always_comb begin
    press     = gif.btn & ~btn_prev_q;
    any_press = |press;
    first_hot = '0;
    press_idx = '0;
    cur_score = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (press[i] && (first_hot == '0)) begin
        first_hot[i] = 1'b1;
        press_idx    = 3'(i);
        cur_score    = score_q[i];
      end
    end
    nxt_score = (cur_score == '1) ? cur_score : cur_score + 1'b1;
    match_win = (nxt_score == WIN_VAL);
    rand_v    = gif.rand_ms;
    delay_d   = MIN_DELAY + TIMER_W'(rand_v);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      blink_q      <= 1'b0;
      cnt_q        <= '0;
      phase_q      <= '0;
      delay_q      <= '0;
      elapsed_q    <= '0;
      winner_ms_q  <= '0;
      winner_id_q  <= '0;
      cheater_id_q <= '0;
      round_done_q <= 1'b0;
      btn_prev_q   <= '1;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      btn_prev_q   <= gif.btn;
      round_done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RESULT, S_FOUL, S_TIMEOUT, S_MATCH_OVER: begin
          if (gif.start) begin
            state_q <= S_BLINK;
            cnt_q   <= '0;
            phase_q <= '0;
            blink_q <= 1'b1;
            if (state_q == S_MATCH_OVER) begin
              for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
            end
          end
        end
        // phase_q wraps every BLINK_HALF_MS ticks, i.e. whenever cnt hits a multiple.
        S_BLINK: begin
          if (gif.ms_tick) begin
            if (cnt_q == BLINK_LAST) begin
              state_q <= S_WAIT;
              cnt_q   <= '0;
              delay_q <= delay_d;
              blink_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (phase_q == HALF_LAST) begin
                phase_q <= '0;
                blink_q <= ~blink_q;
              end else begin
                phase_q <= phase_q + 1'b1;
              end
            end
          end
        end
        S_WAIT: begin
          if (any_press) begin
            state_q      <= S_FOUL;
            cheater_id_q <= press_idx;
            round_done_q <= 1'b1;
          end else if (gif.ms_tick) begin
            if (cnt_q == delay_q - 1'b1) begin
              state_q   <= S_RACE;
              cnt_q     <= '0;
              elapsed_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_RACE: begin
          if (any_press) begin
            winner_ms_q  <= elapsed_q;
            winner_id_q  <= press_idx;
            round_done_q <= 1'b1;
            state_q      <= match_win ? S_MATCH_OVER : S_RESULT;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
              if (first_hot[i]) score_q[i] <= nxt_score;
            end
          end else if (gif.ms_tick) begin
            elapsed_q <= elapsed_q + 1'b1;
            if (elapsed_q == TIMEOUT_LAST) begin
              state_q      <= S_TIMEOUT;
              round_done_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    gif.scores = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      gif.scores[i*SCORE_W +: SCORE_W] = score_q[i];
    end
  end

  assign gif.state      = state_q;
  assign gif.blink      = blink_q;
  assign gif.elapsed_ms = elapsed_q;
  assign gif.winner_ms  = winner_ms_q;
  assign gif.winner_id  = winner_id_q;
  assign gif.cheater_id = cheater_id_q;
  assign gif.round_done = round_done_q;

endmodule

// File: tb/tb_reaction_game_multi.sv
// Directed bench for reaction_game_multi at default parameters, with
// ms_tick pulsing every second clock.
module tb_reaction_game_multi;

  localparam int unsigned ST_IDLE   = 0;
  localparam int unsigned ST_BLINK  = 1;
  localparam int unsigned ST_WAIT   = 2;
  localparam int unsigned ST_RACE   = 3;
  localparam int unsigned ST_RESULT = 4;
  localparam int unsigned ST_FOUL   = 5;
  localparam int unsigned ST_TMO    = 6;
  localparam int unsigned ST_MATCH  = 7;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  reaction_game_multi_if #(
    .NUM_PLAYERS(4), .TIMER_W(20), .RAND_W(14), .SCORE_W(4)
  ) gif ();

  reaction_game_multi #(
    .NUM_PLAYERS(4), .TIMER_W(20), .RAND_W(14), .SCORE_W(4), .WIN_SCORE(5),
    .BLINK_MS(2000), .BLINK_HALF_MS(250), .MIN_DELAY_MS(500), .TIMEOUT_MS(5000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle clock, then one clock with ms_tick high; returns just after the tick edge.
  task automatic ms();
    step();
    gif.ms_tick = 1'b1;
    step();
    gif.ms_tick = 1'b0;
  endtask

  task automatic ms_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) ms();
  endtask

  task automatic pulse_start();
    gif.start = 1'b1;
    step();
    gif.start = 1'b0;
  endtask

  task automatic run_until(input int unsigned from_st, input int unsigned bound,
                           output int unsigned n);
    n = 0;
    while (gif.state == 3'(from_st) && n < bound) begin
      ms();
      n++;
    end
  endtask

  task automatic go_race(input string tag);
    int unsigned n;
    pulse_start();
    run_until(ST_BLINK, 2100, n);
    check({tag, "_blink_len"}, n, 2000);
    run_until(ST_WAIT, 700, n);
    check({tag, "_wait_len"}, n, 600);
    check({tag, "_race"}, gif.state, ST_RACE);
  endtask

  initial begin
    int unsigned n;
    int unsigned toggles;
    logic        prev_blink;

    reset       = 1'b1;
    gif.ms_tick = 1'b0;
    gif.btn     = '0;
    gif.start   = 1'b0;
    gif.rand_ms = 14'd100;
    step();
    step();
    reset = 1'b0;

    check("rst_state", gif.state, ST_IDLE);
    check("rst_blink", gif.blink, 0);
    check("rst_elapsed", gif.elapsed_ms, 0);
    check("rst_scores", gif.scores, 0);
    check("rst_done", gif.round_done, 0);

    // Round 1: blink/wait lengths and a plain win by player 2
    pulse_start();
    check("r1_blink_state", gif.state, ST_BLINK);
    check("r1_blink_start", gif.blink, 1);
    toggles    = 1;
    prev_blink = gif.blink;
    n          = 0;
    while (gif.state == 3'(ST_BLINK) && n < 2100) begin
      ms();
      n++;
      if (gif.blink != prev_blink) toggles++;
      prev_blink = gif.blink;
    end
    check("r1_blink_len", n, 2000);
    check("r1_blink_toggles", toggles, 8);
    check("r1_wait_state", gif.state, ST_WAIT);
    run_until(ST_WAIT, 700, n);
    check("r1_wait_len", n, 600);
    check("r1_race_state", gif.state, ST_RACE);
    check("r1_race_elapsed0", gif.elapsed_ms, 0);
    ms_n(237);
    check("r1_elapsed", gif.elapsed_ms, 237);
    gif.btn = 4'b0100;
    step();
    gif.btn = 4'b0000;
    check("r1_state", gif.state, ST_RESULT);
    check("r1_winner_ms", gif.winner_ms, 237);
    check("r1_winner_id", gif.winner_id, 2);
    check("r1_scores", gif.scores, 32'h0100);
    check("r1_done_hi", gif.round_done, 1);
    step();
    check("r1_done_lo", gif.round_done, 0);
    gif.btn = 4'b0001;
    step();
    gif.btn = 4'b0000;
    check("r1_press_ignored", gif.state, ST_RESULT);
    check("r1_scores_hold", gif.scores, 32'h0100);

    // Round 2: foul by player 1 ten ms into WAIT
    pulse_start();
    run_until(ST_BLINK, 2100, n);
    check("r2_blink_len", n, 2000);
    ms_n(10);
    check("r2_still_wait", gif.state, ST_WAIT);
    gif.btn = 4'b0010;
    step();
    gif.btn = 4'b0000;
    check("r2_state", gif.state, ST_FOUL);
    check("r2_cheater", gif.cheater_id, 1);
    check("r2_scores", gif.scores, 32'h0100);
    check("r2_done", gif.round_done, 1);
    pulse_start();
    check("r2_restart", gif.state, ST_BLINK);

    // Round 3: players 0 and 3 press together on a tick clock; 0 wins with pre-tick time
    run_until(ST_BLINK, 2100, n);
    run_until(ST_WAIT, 700, n);
    check("r3_race", gif.state, ST_RACE);
    ms_n(20);
    step();
    gif.ms_tick = 1'b1;
    gif.btn     = 4'b1001;
    step();
    gif.ms_tick = 1'b0;
    gif.btn     = 4'b0000;
    check("r3_state", gif.state, ST_RESULT);
    check("r3_winner_id", gif.winner_id, 0);
    check("r3_winner_ms", gif.winner_ms, 20);
    check("r3_scores", gif.scores, 32'h0101);

    // Round 4: no press until timeout
    go_race("r4");
    run_until(ST_RACE, 5100, n);
    check("r4_race_len", n, 5000);
    check("r4_state", gif.state, ST_TMO);
    check("r4_elapsed", gif.elapsed_ms, 5000);
    check("r4_done", gif.round_done, 1);
    check("r4_scores", gif.scores, 32'h0101);

    // Rounds 5-9: player 3 wins five times, the last one ends the match
    for (int unsigned k = 0; k < 5; k++) begin
      go_race("p3");
      ms_n(10 + k);
      gif.btn = 4'b1000;
      step();
      gif.btn = 4'b0000;
      check("p3_state", gif.state, (k == 4) ? ST_MATCH : ST_RESULT);
      check("p3_scores", gif.scores, 32'h0101 | ((k + 1) << 12));
      check("p3_winner_ms", gif.winner_ms, 10 + k);
    end
    check("match_done", gif.round_done, 1);
    pulse_start();
    check("match_restart", gif.state, ST_BLINK);
    check("match_clear", gif.scores, 0);

    // Buttons held through reset and into WAIT/RACE never register
    gif.btn = 4'b1111;
    reset   = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst2_state", gif.state, ST_IDLE);
    go_race("held");
    ms_n(48);
    gif.btn = 4'b0000;
    ms_n(2);
    check("held_state", gif.state, ST_RACE);
    check("held_elapsed", gif.elapsed_ms, 50);

    // Reset mid-race with a simultaneous press: capture is lost
    gif.btn = 4'b0010;
    reset   = 1'b1;
    step();
    reset   = 1'b0;
    gif.btn = 4'b0000;
    check("mid_state", gif.state, ST_IDLE);
    check("mid_elapsed", gif.elapsed_ms, 0);
    check("mid_winner_ms", gif.winner_ms, 0);
    check("mid_winner_id", gif.winner_id, 0);
    check("mid_cheater", gif.cheater_id, 0);
    check("mid_scores", gif.scores, 0);
    check("mid_blink", gif.blink, 0);
    check("mid_done", gif.round_done, 0);
    step();
    check("mid_idle_hold", gif.state, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
